mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory stage for the multi-cycle RV32 core. Sits directly downstream of the ALU result register: takes the effective address (ALU F) and store data (register port B), and drives a synchronous data RAM.
- Handles LB/LH/LW/LBU/LHU/SB/SH/SW, including byte-lane formatting, sign/zero extension and misalignment detection.
- Started by the CU with a one-cycle start pulse; returns a one-cycle done pulse that the CU uses to advance to write-back.

Parameters:
- ADDR_W, 6: word-address width of the data RAM (64 x 32-bit words).
- RD_LAT, 1: RAM read latency in cycles, counted from the cycle ram_en is high to the cycle ram_rdata is valid; legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse from the CU; sampled only in IDLE.
- is_load  in  1  request is a load.
- is_store  in  1  request is a store.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address (ALU F).
- store_data  in  32  rs2 data.
- ram_en  out  1  RAM access strobe.
- ram_we  out  4  per-byte write enables.
- ram_addr  out  ADDR_W  word address, equal to addr_q[ADDR_W+1:2].
- ram_wdata  out  32  lane-replicated store data.
- ram_rdata  in  32  RAM read data.
- load_data  out  32  extended load result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; flags a misaligned or illegal request.

Behaviour:
- Reset (rst=1 at a clock edge): state goes to IDLE; load_data=0, done=0, err=0, busy=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, counter=0. Reset during any state aborts the operation in that same edge; no write is issued after reset.
- States:
  - IDLE: if start=1, latch is_load, is_store, funct3, addr, store_data.
    - Legal request: go to ACCESS.
    - Illegal request: go to DONE with err pending.
  - ACCESS: ram_en=1; ram_we = store mask (0000 for loads). Store goes to DONE. Load goes to WAIT with cnt=RD_LAT-1.
  - WAIT: while cnt!=0, decrement cnt. When cnt==0, register the extracted ram_rdata into load_data and go to DONE.
  - DONE: done=1 and err valid for exactly one cycle, then go to IDLE.
- Outputs: ram_* are decoded from the registered state and latched inputs only, so they never depend combinationally on start, addr or the other request inputs.
- Latency, with start sampled at edge t0:
  - Store: ram_en/we high during cycle t0+1; done during cycle t0+2.
  - Load: done during cycle t0+2+RD_LAT; load_data is stable from that cycle until the next load completes.
  - Error: done=err=1 during cycle t0+1; no ram_en is asserted.
- Illegal requests:
  - is_load==is_store (both 0 or both 1).
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - H/HU/SH with addr[0]=1.
  - W/SW with addr[1:0]!=00.
  - On error, load_data is left unchanged.
- Store formatting:
  - SB: wdata={4{sd[7:0]}}, we=0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, we = addr[1] ? 1100 : 0011.
  - SW: wdata=sd, we=1111.
- Load extraction:
  - Byte = ram_rdata[8*addr[1:0]+:8]; halfword = ram_rdata[16*addr[1]+:16].
  - B/H sign-extend; BU/HU zero-extend.
- Address range: addr bits above ADDR_W+1 are ignored (wrap within the RAM).
- start while busy is ignored; the request is not queued.
- start in the DONE cycle is also ignored.

Decomposition:
- Shared package holds: funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), the FSM state encoding (IDLE, ACCESS, WAIT, DONE), and a RAM word-count localparam derived from ADDR_W.
- One natural sub-module, lsu_align: purely combinational. It produces the store mask and wdata, the load extraction/extension, and the misalign/illegal flag. It is shared by the FSM for the legality check.

Test Plan:
- SW store_data=32'hDEADBEEF, addr=32'h8 -> during t0+1 ram_en=1, ram_we=1111, ram_addr=2, ram_wdata=DEADBEEF; done=1, err=0 at t0+2.
- SB store_data=32'h000000A5, addr=32'hD -> ram_we=0010, ram_addr=3, ram_wdata=A5A5A5A5; a subsequent LW of addr 0xC with RAM initially 0 returns 0000A500.
- RAM word 1 = 32'h80F17F80, RD_LAT=1:
  - LB addr 5 -> FFFFFF7F? no: byte1=7F -> 0000007F.
  - LB addr 4 -> FFFFFF80.
  - LBU addr 4 -> 00000080.
  - LH addr 6 -> FFFF80F1.
  - LHU addr 6 -> 000080F1.
  - Each load has done at t0+3.
- Misaligned LW addr=32'h6 and SH addr=32'h3 -> done=err=1 at t0+1; ram_en never high; load_data unchanged.
- start re-pulsed during WAIT, and rst asserted in ACCESS of a SW -> the second start is ignored (single done). After the reset edge: state IDLE, ram_we=0, busy=0, and the RAM contents are untouched on the following cycle.
- RD_LAT=3 with LW addr 0 -> done at t0+5; busy high for cycles t0+1..t0+5.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory stage: access-size codes, FSM states, RAM geometry.
package mem_access_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } state_t;

   localparam int DEF_ADDR_W    = 6;
   localparam int DEF_RAM_WORDS = 1 << DEF_ADDR_W;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting for stores, extraction/extension for loads, and request legality.
// Purely combinational; no flow control of its own.
module lsu_align
   import mem_access_unit_pkg::*;
(
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  we_mask,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        illegal
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        bad_f3;
   logic        misalign;

   assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
   assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      bad_f3    = 1'b0;
      misalign  = 1'b0;
      we_mask   = 4'b0000;
      wdata     = store_data;
      load_data = rdata;
      case (funct3)
         F3_B: begin
            we_mask   = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{lane_b[7]}}, lane_b};
         end
         F3_BU: begin
            bad_f3    = is_store;
            load_data = {24'h000000, lane_b};
         end
         F3_H: begin
            misalign  = addr_lo[0];
            we_mask   = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{lane_h[15]}}, lane_h};
         end
         F3_HU: begin
            bad_f3    = is_store;
            misalign  = addr_lo[0];
            load_data = {16'h0000, lane_h};
         end
         F3_W: begin
            misalign  = addr_lo != 2'b00;
            we_mask   = 4'b1111;
         end
         default: bad_f3 = 1'b1;
      endcase
      if (!is_store) we_mask = 4'b0000;
      illegal = (is_load == is_store) | bad_f3 | misalign;
   end

endmodule

// File: rtl/mem_access_unit.sv
// RV32 data-memory stage: start pulse in, one-cycle done/err out; store done at t0+2, load at t0+2+RD_LAT.
// No queueing: start is only honoured in IDLE, anything arriving while busy is dropped.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_LAT = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_load,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [31:0]       store_data,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       load_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

   state_t            state;
   logic              ld_q;
   logic              st_q;
   logic [2:0]        f3_q;
   logic [ADDR_W+1:0] addr_q;
   logic              err_q;
   logic              en_q;
   logic [3:0]        we_q;
   logic [31:0]       wdata_q;
   logic [31:0]       load_q;
   logic [1:0]        cnt;

   logic              idle;
   logic              req_ld;
   logic              req_st;
   logic [2:0]        req_f3;
   logic [1:0]        req_lo;
   logic [3:0]        al_we;
   logic [31:0]       al_wdata;
   logic [31:0]       al_load;
   logic              al_illegal;
   logic              unused_addr_hi;

   // The aligner looks at the live request while idle (legality, store lanes)
   // and at the latched request afterwards (load extraction).
   assign idle   = state == IDLE;
   assign req_ld = idle ? is_load  : ld_q;
   assign req_st = idle ? is_store : st_q;
   assign req_f3 = idle ? funct3   : f3_q;
   assign req_lo = idle ? addr[1:0] : addr_q[1:0];

   lsu_align u_align (
      .is_load    (req_ld),
      .is_store   (req_st),
      .funct3     (req_f3),
      .addr_lo    (req_lo),
      .store_data (store_data),
      .rdata      (ram_rdata),
      .we_mask    (al_we),
      .wdata      (al_wdata),
      .load_data  (al_load),
      .illegal    (al_illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ld_q    <= 1'b0;
         st_q    <= 1'b0;
         f3_q    <= F3_B;
         addr_q  <= '0;
         err_q   <= 1'b0;
         en_q    <= 1'b0;
         we_q    <= 4'b0000;
         wdata_q <= 32'h0;
         load_q  <= 32'h0;
         cnt     <= 2'd0;
      end else begin
         case (state)
            IDLE: if (start) begin
               ld_q   <= is_load;
               st_q   <= is_store;
               f3_q   <= funct3;
               addr_q <= addr[ADDR_W+1:0];
               err_q  <= al_illegal;
               if (al_illegal) begin
                  state <= DONE;
               end else begin
                  state   <= ACCESS;
                  en_q    <= 1'b1;
                  we_q    <= al_we;
                  wdata_q <= al_wdata;
               end
            end
            ACCESS: begin
               en_q <= 1'b0;
               we_q <= 4'b0000;
               if (st_q) begin
                  state <= DONE;
               end else begin
                  cnt   <= CNT_INIT;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != 2'd0) begin
                  cnt <= cnt - 2'd1;
               end else begin
                  load_q <= al_load;
                  state  <= DONE;
               end
            end
            DONE: begin
               err_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset kills the strobe in the very cycle it is asserted, so an access
   // caught by reset never reaches the RAM.
   assign ram_en    = en_q & ~rst;
   assign ram_we    = we_q & {4{~rst}};
   assign ram_addr  = addr_q[ADDR_W+1:2];
   assign ram_wdata = wdata_q;
   assign load_data = load_q;
   assign busy      = !idle;
   assign done      = state == DONE;
   assign err       = err_q;

   assign unused_addr_hi = ^addr[31:ADDR_W+2];

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, multi-cycle corner sequences, random vs. byte-level model.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int AW = DEF_ADDR_W;

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sd;
      logic        exp_err;
      logic [31:0] exp_ld;
      logic [3:0]  exp_we;
      logic [31:0] exp_wd;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start1, start3, is_load, is_store;
   logic [2:0]    funct3;
   logic [31:0]   addr, store_data;
   logic          en1, en3, busy1, busy3, done1, done3, err1, err3;
   logic [3:0]    we1, we3;
   logic [AW-1:0] raddr1, raddr3;
   logic [31:0]   wdata1, wdata3, rdata1, rdata3, ld1, ld3;

   mem_access_unit #(.ADDR_W(AW), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .is_load(is_load), .is_store(is_store),
      .funct3(funct3), .addr(addr), .store_data(store_data),
      .ram_en(en1), .ram_we(we1), .ram_addr(raddr1), .ram_wdata(wdata1), .ram_rdata(rdata1),
      .load_data(ld1), .busy(busy1), .done(done1), .err(err1));

   mem_access_unit #(.ADDR_W(AW), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .is_load(is_load), .is_store(is_store),
      .funct3(funct3), .addr(addr), .store_data(store_data),
      .ram_en(en3), .ram_we(we3), .ram_addr(raddr3), .ram_wdata(wdata3), .ram_rdata(rdata3),
      .load_data(ld3), .busy(busy3), .done(done3), .err(err3));

   // RAM models; read data is poisoned whenever no access was made.
   logic [31:0]   mem1 [DEF_RAM_WORDS];
   logic [31:0]   mem3 [DEF_RAM_WORDS];
   logic [31:0]   p3 [3];
   logic          clr, pre_we1, pre_we3;
   logic [AW-1:0] pre_addr;
   logic [31:0]   pre_val;

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEF_RAM_WORDS; i++) begin
            mem1[i] <= 32'h0;
            mem3[i] <= 32'h0;
         end
      end else begin
         if (pre_we1) mem1[pre_addr] <= pre_val;
         if (pre_we3) mem3[pre_addr] <= pre_val;
         for (int b = 0; b < 4; b++) begin
            if (en1 && we1[b]) mem1[raddr1][8*b +: 8] <= wdata1[8*b +: 8];
            if (en3 && we3[b]) mem3[raddr3][8*b +: 8] <= wdata3[8*b +: 8];
         end
      end
      rdata1 <= en1 ? mem1[raddr1] : 32'hBAD0BAD0;
      p3[0]  <= en3 ? mem3[raddr3] : 32'hBAD0BAD0;
      p3[1]  <= p3[0];
      p3[2]  <= p3[1];
   end
   assign rdata3 = p3[2];

   int nvec = 0;
   int nerr = 0;
   logic [7:0] rm [256];
   logic [31:0] rm_ld;
   logic [2:0]  ld_f3s [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
   vec_t tbl [18];

   task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s/%s: got %h, expected %h", tag, name, act, exp);
      end
   endtask

   task automatic preload(input logic to3, input logic [AW-1:0] a, input logic [31:0] v);
      pre_addr = a;
      pre_val  = v;
      pre_we1  = !to3;
      pre_we3  = to3;
      @(negedge clk);
      pre_we1 = 1'b0;
      pre_we3 = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      clr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clr = 1'b0;
      chk(tag, "load_data", ld1, 32'h0);
      chk(tag, "busy", 32'(busy1), 32'h0);
      chk(tag, "done", 32'(done1), 32'h0);
      chk(tag, "err", 32'(err1), 32'h0);
      chk(tag, "ram_en", 32'(en1), 32'h0);
      chk(tag, "ram_we", 32'(we1), 32'h0);
      chk(tag, "ram_addr", 32'(raddr1), 32'h0);
      chk(tag, "ram_wdata", wdata1, 32'h0);
      chk(tag, "busy3", 32'(busy3), 32'h0);
      chk(tag, "load_data3", ld3, 32'h0);
   endtask

   // One request on the RD_LAT=1 instance; called and returns on a falling edge.
   task automatic run_req(input vec_t v, input string tag);
      int          cyc;
      int          lat;
      logic        seen;
      logic [3:0]  wec;
      logic [31:0] wdc;
      logic [AW-1:0] rac;
      is_load    = v.ld;
      is_store   = v.st;
      funct3     = v.f3;
      addr       = v.a;
      store_data = v.sd;
      start1     = 1'b1;
      @(negedge clk);
      start1     = 1'b0;
      is_load    = ~v.ld;
      funct3     = 3'($urandom);
      addr       = $urandom;
      store_data = $urandom;
      cyc  = 1;
      seen = 1'b0;
      wec  = 4'h0;
      wdc  = 32'h0;
      rac  = '0;
      while (!done1 && cyc < 12) begin
         if (en1) begin
            seen = 1'b1;
            wec  = we1;
            wdc  = wdata1;
            rac  = raddr1;
         end
         @(negedge clk);
         cyc++;
      end
      lat = v.exp_err ? 1 : (v.st ? 2 : 3);
      chk(tag, "latency", 32'(cyc), 32'(lat));
      chk(tag, "err", 32'(err1), 32'(v.exp_err));
      chk(tag, "load_data", ld1, v.exp_ld);
      chk(tag, "ram_en_seen", 32'(seen), 32'(!v.exp_err));
      if (!v.exp_err) begin
         chk(tag, "ram_we", 32'(wec), 32'(v.exp_we));
         chk(tag, "ram_addr", 32'(rac), (v.a >> 2) & 32'd63);
         if (v.st) chk(tag, "ram_wdata", wdc, v.exp_wd);
      end
      @(negedge clk);
      chk(tag, "done_pulse", 32'(done1), 32'h0);
      chk(tag, "idle_after", 32'(busy1), 32'h0);
   endtask

   initial begin
      int   ndone;
      int   cyc;
      int   nbusy;
      int   k;
      int   n;
      int   base;
      vec_t v;

      rst = 1'b1; clr = 1'b0; start1 = 1'b0; start3 = 1'b0;
      is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
      pre_we1 = 1'b0; pre_we3 = 1'b0; pre_addr = '0; pre_val = 32'h0;

      tbl[0]  = '{1'b0, 1'b1, F3_W,   32'h8,        32'hDEADBEEF, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF};
      tbl[1]  = '{1'b0, 1'b1, F3_B,   32'hD,        32'h000000A5, 1'b0, 32'h0,        4'b0010, 32'hA5A5A5A5};
      tbl[2]  = '{1'b1, 1'b0, F3_W,   32'hC,        32'h0,        1'b0, 32'h0000A500, 4'b0000, 32'h0};
      tbl[3]  = '{1'b1, 1'b0, F3_B,   32'h5,        32'h0,        1'b0, 32'h0000007F, 4'b0000, 32'h0};
      tbl[4]  = '{1'b1, 1'b0, F3_B,   32'h4,        32'h0,        1'b0, 32'hFFFFFF80, 4'b0000, 32'h0};
      tbl[5]  = '{1'b1, 1'b0, F3_BU,  32'h4,        32'h0,        1'b0, 32'h00000080, 4'b0000, 32'h0};
      tbl[6]  = '{1'b1, 1'b0, F3_H,   32'h6,        32'h0,        1'b0, 32'hFFFF80F1, 4'b0000, 32'h0};
      tbl[7]  = '{1'b1, 1'b0, F3_HU,  32'h6,        32'h0,        1'b0, 32'h000080F1, 4'b0000, 32'h0};
      tbl[8]  = '{1'b1, 1'b0, F3_W,   32'h6,        32'h0,        1'b1, 32'h000080F1, 4'b0000, 32'h0};
      tbl[9]  = '{1'b0, 1'b1, F3_H,   32'h3,        32'h11223344, 1'b1, 32'h000080F1, 4'b0000, 32'h0};
      tbl[10] = '{1'b0, 1'b0, F3_W,   32'h0,        32'h0,        1'b1, 32'h000080F1, 4'b0000, 32'h0};
      tbl[11] = '{1'b1, 1'b1, F3_W,   32'h0,        32'h0,        1'b1, 32'h000080F1, 4'b0000, 32'h0};
      tbl[12] = '{1'b1, 1'b0, 3'b011, 32'h0,        32'h0,        1'b1, 32'h000080F1, 4'b0000, 32'h0};
      tbl[13] = '{1'b0, 1'b1, F3_BU,  32'h0,        32'h55,       1'b1, 32'h000080F1, 4'b0000, 32'h0};
      tbl[14] = '{1'b0, 1'b1, F3_H,   32'hA,        32'h1234BEEF, 1'b0, 32'h000080F1, 4'b1100, 32'hBEEFBEEF};
      tbl[15] = '{1'b1, 1'b0, F3_W,   32'h8,        32'h0,        1'b0, 32'hBEEFBEEF, 4'b0000, 32'h0};
      tbl[16] = '{1'b1, 1'b0, F3_H,   32'hFFFFFF0A, 32'h0,        1'b0, 32'hFFFFBEEF, 4'b0000, 32'h0};
      tbl[17] = '{1'b1, 1'b0, F3_BU,  32'hD,        32'h0,        1'b0, 32'h000000A5, 4'b0000, 32'h0};

      do_reset("reset");
      preload(1'b0, 6'd1, 32'h80F17F80);
      for (int i = 0; i < 18; i++) run_req(tbl[i], $sformatf("tbl%0d", i));

      // Extra starts during WAIT and during DONE must be dropped.
      is_load = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h4; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      addr = 32'h8; start1 = 1'b1;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done1) ndone++;
         if (i == 1) begin
            chk("restart", "idle_after_done", 32'(busy1), 32'h0);
            start1 = 1'b0;
         end
      end
      chk("restart", "done_count", 32'(ndone), 32'd1);
      chk("restart", "load_data", ld1, 32'h80F17F80);

      // Reset landing on the ACCESS cycle of a store.
      preload(1'b0, 6'd5, 32'h12345678);
      is_load = 1'b0; is_store = 1'b1; funct3 = F3_W; addr = 32'h14; store_data = 32'hFFFFFFFF;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("rst_access", "access_seen", 32'(en1), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_access", "busy", 32'(busy1), 32'h0);
      chk("rst_access", "ram_we", 32'(we1), 32'h0);
      chk("rst_access", "ram_en", 32'(en1), 32'h0);
      chk("rst_access", "load_data", ld1, 32'h0);
      ndone = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done1) ndone++;
      end
      chk("rst_access", "ram_word", mem1[5], 32'h12345678);
      chk("rst_access", "done_count", 32'(ndone), 32'd0);

      // RD_LAT=3: done at t0+5, busy for t0+1..t0+5.
      preload(1'b1, 6'd0, 32'hCAFEF00D);
      is_load = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h0; start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      cyc = 1;
      nbusy = 0;
      while (!done3 && cyc < 15) begin
         if (busy3) nbusy++;
         @(negedge clk);
         cyc++;
      end
      chk("lat3", "latency", 32'(cyc), 32'd5);
      chk("lat3", "busy_cycles", 32'(nbusy + (busy3 ? 1 : 0)), 32'd5);
      chk("lat3", "load_data", ld3, 32'hCAFEF00D);
      chk("lat3", "err", 32'(err3), 32'h0);
      @(negedge clk);
      chk("lat3", "busy_after", 32'(busy3), 32'h0);

      // Random requests against a byte-addressed model of the 256-byte RAM.
      do_reset("reset2");
      for (int i = 0; i < 256; i++) rm[i] = 8'h00;
      rm_ld = 32'h0;
      for (int t = 0; t < 300; t++) begin
         k = $urandom_range(0, 19);
         if (k == 0) begin v.ld = 1'b0; v.st = 1'b0; end
         else if (k == 1) begin v.ld = 1'b1; v.st = 1'b1; end
         else begin v.ld = (k % 2) == 1; v.st = (k % 2) == 0; end
         if ($urandom_range(0, 3) == 0) v.f3 = 3'($urandom_range(0, 7));
         else if (v.st) v.f3 = 3'($urandom_range(0, 2));
         else v.f3 = ld_f3s[$urandom_range(0, 4)];
         v.a = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 31));
         n = 1 << v.f3[1:0];
         if ($urandom_range(0, 3) != 0) v.a = v.a - (v.a % n);
         v.sd = $urandom;
         v.exp_we = 4'h0;
         v.exp_wd = 32'h0;
         base = int'(v.a % 256);
         v.exp_err = (v.ld == v.st) || (v.st && v.f3 > 3'd2) ||
                     (v.ld && (v.f3 == 3'd3 || v.f3 > 3'd5)) || ((v.a % n) != 0);
         if (!v.exp_err && v.ld) begin
            rm_ld = 32'h0;
            for (int i = 0; i < n; i++) rm_ld[8*i +: 8] = rm[base + i];
            if (!v.f3[2] && n < 4 && rm_ld[8*n-1])
               for (int i = n; i < 4; i++) rm_ld[8*i +: 8] = 8'hFF;
         end
         if (!v.exp_err && v.st) begin
            v.exp_we = 4'(((1 << n) - 1) << (v.a % 4));
            for (int i = 0; i < 4; i++) v.exp_wd[8*i +: 8] = v.sd[8*(i % n) +: 8];
            for (int i = 0; i < n; i++) rm[base + i] = v.sd[8*i +: 8];
         end
         v.exp_ld = rm_ld;
         run_req(v, $sformatf("rnd%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
